mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multi-cycle multiply/divide responder for the MIPS datapath, the sequential counterpart to the single-cycle ALU.
- The execute stage issues a request (op, a, b) with a start pulse. The unit computes over 32 iterations and returns results in HI/LO with a one-cycle done pulse.
- Serves MULT, MULTU, DIV and DIVU. MFHI/MFLO read the hi/lo outputs directly.

Parameters:
- WIDTH, 32, operand width. HI/LO are each WIDTH bits. Iteration count equals WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only when busy=0.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  multiplicand / dividend (rs).
- b  input  WIDTH  multiplier / divisor (rt).
- flush  input  1  synchronous cancel of the in-flight operation.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when hi/lo have been updated.
- dz  output  1  divide-by-zero flag of the last completed op; held until next completion.
- hi  output  WIDTH  HI register: product upper half, or remainder.
- lo  output  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Reset (RST=1 at an edge, overrides everything): state=IDLE, busy=0, done=0, dz=0, hi=0, lo=0, iteration counter=0.
- States: IDLE -> PREP -> CALC -> FIX -> IDLE.
- IDLE:
  - busy=0.
  - If start=1 at an edge, latch op, a, b and go to PREP.
  - No-op otherwise.
- PREP (1 cycle):
  - Signed ops (MULT, DIV): convert a and b to magnitudes.
  - Record result sign: a[W-1]^b[W-1] for MULT and quotient. Record remainder sign: a[W-1].
  - Unsigned ops use raw values.
  - Clear the 2W-bit accumulator and set counter=0.
- CALC (exactly WIDTH cycles, counter 0..WIDTH-1):
  - Multiply: radix-2 shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring shift-subtract, one quotient bit per cycle, MSB first.
  - After counter=WIDTH-1, go to FIX.
- FIX (1 cycle):
  - Apply sign correction: two's complement of the 2W product, quotient, or remainder as recorded.
  - Write hi/lo and dz. Set done=1 for the next cycle only. Return to IDLE.
- busy=1 in PREP, CALC and FIX; busy=0 in IDLE, including the done cycle.
- Latency: start sampled at edge k; hi/lo/done are visible after edge k+WIDTH+2 (edge k+34 for WIDTH=32).
- Back-to-back: start is accepted in the same cycle done=1.
- start while busy=1: ignored. Latched operands do not change.
- hi/lo hold their previous values for the whole operation and change only at the FIX edge.
- Divide by zero (b=0, DIV or DIVU):
  - Full latency still applies.
  - dz=1, lo=all ones, hi=a (original, unsigned-interpreted, no sign fix).
- Any completed multiply, or divide with b≠0, writes dz=0.
- DIV 0x80000000 / 0xFFFFFFFF (overflow): lo=0x80000000, hi=0, dz=0. This is the natural result of the magnitude algorithm.
- Remainder sign follows the dividend. Quotient truncates toward zero.
- flush=1 at an edge:
  - Any non-IDLE state returns to IDLE. No done pulse; hi/lo/dz unchanged.
  - If flush and start occur together in IDLE, flush wins and start is ignored.
- RST mid-operation: immediate reset values; no done.
- Input changes on a and b after start is accepted have no effect.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at edge k -> busy=1 edges k+1..k+33; at k+34 done=1, hi=0xFFFFFFFE, lo=0x00000001, dz=0.
- MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then back-to-back start on the done cycle with DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> done at k+34, dz=1, lo=0xFFFFFFFF, hi=100. A following MULTU 2*3 -> dz=0, hi=0, lo=6.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, dz=0.
- Interference: start DIVU 1000/7, pulse start with other operands at k+5, change a/b every cycle -> one done only, at k+34, with lo=142, hi=6.
- Cancel and reset: flush at k+10 -> no done ever, hi/lo keep prior values, busy=0 after k+10. Repeat with RST at k+10 -> hi=lo=0, dz=0, done=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit for the MIPS execute stage.
// It runs MULT, MULTU, DIV and DIVU in WIDTH+2 cycles: a PREP cycle, WIDTH
// CALC cycles and a FIX cycle. Results land in HI/LO along with a one-cycle
// done pulse.
//
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   start          request strobe, accepted only in IDLE
//   op[1:0]        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b           rs / rt operands (latched on accept)
//   flush          cancels the in-flight op; hi/lo/dz are left untouched
//   busy           high in PREP, CALC and FIX
//   done           one-cycle pulse after hi/lo are written
//   dz             divide-by-zero flag of the last completed op
//   hi, lo         product {hi,lo}, or remainder/quotient
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc_q;
    // mag_q holds the fixed operand: the multiplicand, or the divisor.
    // opnd_q holds the operand that is shifted: the multiplier (shifted
    // right) or the dividend (shifted left).
    logic [WIDTH-1:0]   mag_q, opnd_q;
    logic               qneg_q, rneg_q;
    logic               done_q, dz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               is_div, is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_rem, div_diff;
    logic [2*WIDTH-1:0] acc_d, prod_fix;
    logic [WIDTH-1:0]   opnd_d, quo_fix, rem_fix;

    always_comb begin
        is_div    = op_q[1];
        is_signed = ~op_q[0];
        a_mag     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
        b_mag     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

        // Multiply step: add the multiplicand into the upper half if the
        // current multiplier bit is set, then shift the sum right. The carry
        // bit rides along in mul_sum[WIDTH].
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opnd_q[0] ? {1'b0, mag_q} : '0);

        // Restoring divide step: shift the next dividend bit into the
        // partial remainder. When the subtraction produces no borrow, keep
        // the difference and shift a 1 into the quotient.
        div_rem  = {acc_q[2*WIDTH-1:WIDTH], opnd_q[WIDTH-1]};
        div_diff = div_rem - {1'b0, mag_q};

        if (is_div) begin
            if (!div_diff[WIDTH])
                acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            opnd_d = opnd_q << 1;
        end else begin
            acc_d  = {mul_sum, acc_q[WIDTH-1:1]};
            opnd_d = opnd_q >> 1;
        end

        prod_fix = qneg_q ? -acc_q : acc_q;
        quo_fix  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            mag_q   <= '0;
            opnd_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                // A flush in IDLE also wins over a simultaneous start.
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            op_q    <= op;
                            a_q     <= a;
                            b_q     <= b;
                            state_q <= S_PREP;
                        end
                    end
                    S_PREP: begin
                        mag_q   <= is_div ? b_mag : a_mag;
                        opnd_q  <= is_div ? a_mag : b_mag;
                        qneg_q  <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                        rneg_q  <= is_signed & a_q[WIDTH-1];
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_CALC;
                    end
                    S_CALC: begin
                        acc_q  <= acc_d;
                        opnd_q <= opnd_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1))
                            state_q <= S_FIX;
                    end
                    S_FIX: begin
                        if (is_div && (b_q == '0)) begin
                            // Divide by zero returns the raw dividend, with
                            // no sign correction.
                            dz_q <= 1'b1;
                            lo_q <= '1;
                            hi_q <= a_q;
                        end else if (is_div) begin
                            dz_q <= 1'b0;
                            lo_q <= quo_fix;
                            hi_q <= rem_fix;
                        end else begin
                            dz_q <= 1'b0;
                            lo_q <= prod_fix[WIDTH-1:0];
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        end
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit. Expected results are pushed to a
// queue when a request is issued. They are popped and compared when done
// pulses. The bench covers a table of fixed vectors, model-checked random
// vectors, and hand sequences for latency, back-to-back issue, interference,
// flush and reset.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start, flush;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b;
        logic [W-1:0] hi, lo;
        logic         dz;
    } vec_t;

    exp_t sbq[$];
    int   nvec = 0, nmis = 0, ndone = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference model built on 64-bit arithmetic. SystemVerilog division
    // truncates toward zero, and the remainder takes the dividend's sign.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        r;
        longint      sx, sy;
        logic [63:0] p, q, m;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r.dz = 1'b0;
        case (o)
            2'd0: begin p = sx * sy; r.hi = p[63:32]; r.lo = p[31:0]; end
            2'd1: begin p = {32'b0, x} * {32'b0, y}; r.hi = p[63:32]; r.lo = p[31:0]; end
            default: begin
                if (y == '0) begin
                    r.dz = 1'b1; r.lo = '1; r.hi = x;
                end else begin
                    if (o == 2'd2) begin q = sx / sy; m = sx % sy; end
                    else begin q = {32'b0, x} / {32'b0, y}; m = {32'b0, x} % {32'b0, y}; end
                    r.lo = q[31:0]; r.hi = m[31:0];
                end
            end
        endcase
        return r;
    endfunction

    // Monitor: on each done pulse, pop the next expected result and compare.
    always @(posedge CLK) begin
        #1;
        if (!RST && done) begin
            ndone++;
            if (sbq.size() == 0) begin
                nvec++; nmis++;
                $display("FAIL unexpected_done: got done=1, want no pending op");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("dz", dz, e.dz);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
        @(negedge CLK);
        op = o; a = x; b = y; start = 1'b1;
        sbq.push_back(e);
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("done_timeout", 1'b0, 1'b1);
            sbq.delete();
        end
        @(negedge CLK);
    endtask

    function automatic exp_t mk(input logic [W-1:0] h, input logic [W-1:0] l, input logic d);
        exp_t e;
        e.hi = h; e.lo = l; e.dz = d;
        return e;
    endfunction

    vec_t tbl[14];

    initial begin
        int           bad, d0, n;
        logic [W-1:0] hi0, lo0;
        logic         dz0;
        exp_t         e;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;

        tbl[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[1]  = '{2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[2]  = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{2'd3, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
        tbl[4]  = '{2'd1, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0};
        tbl[5]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        tbl[6]  = '{2'd3, 32'd1000,     32'd7,        32'd6,        32'd142,      1'b0};
        tbl[7]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        tbl[8]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[9]  = '{2'd2, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1};
        tbl[10] = '{2'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
        tbl[11] = '{2'd3, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
        tbl[12] = '{2'd2, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0};
        tbl[13] = '{2'd1, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0};

        RST = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_dz", dz, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // Latency and busy window on MULTU all-ones. Start is sampled at edge k.
        @(negedge CLK);
        op = 2'd1; a = '1; b = '1; start = 1'b1;
        sbq.push_back(mk(32'hFFFFFFFE, 32'h1, 1'b0));
        @(posedge CLK);
        #2 start = 1'b0;
        bad = 0;
        for (int i = 1; i <= 34; i++) begin
            @(posedge CLK);
            #2;
            if (i < 34 && (!busy || done)) bad++;
            if (i == 34) begin
                chk("lat_done", done, 1);
                chk("lat_busy_on_done", busy, 0);
            end
        end
        chk("lat_busy_window", bad, 0);
        @(posedge CLK);
        #2 chk("lat_done_one_cycle", done, 0);
        wait_idle();

        // Fixed table
        for (int i = 0; i < 14; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, mk(tbl[i].hi, tbl[i].lo, tbl[i].dz));
            wait_idle();
        end

        // Random vectors against the model
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? '0 : $urandom;
            issue(ro, ra, rb, model(ro, ra, rb));
            wait_idle();
        end

        // Back-to-back: issue DIV in the same cycle that MULT's done is high.
        issue(2'd0, 32'hFFFFFFFD, 32'd7, mk(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0));
        n = 0;
        while (!done && n < 60) begin @(negedge CLK); n++; end
        chk("b2b_done_seen", done, 1);
        op = 2'd2; a = 32'hFFFFFFF9; b = 32'd2; start = 1'b1;
        sbq.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0));
        @(negedge CLK);
        start = 1'b0;
        chk("b2b_accepted", busy, 1);
        wait_idle();

        // Interference: operand churn and a stray start while busy.
        d0 = ndone;
        @(negedge CLK);
        op = 2'd3; a = 32'd1000; b = 32'd7; start = 1'b1;
        sbq.push_back(mk(32'd6, 32'd142, 1'b0));
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            start = (i == 5);
            op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
        end
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge CLK);
        chk("intf_done_count", ndone - d0, 1);

        // Run a divide by zero so that dz=1 beforehand, then flush mid-op.
        issue(2'd3, 32'd55, 32'd0, mk(32'd55, 32'hFFFFFFFF, 1'b1));
        wait_idle();
        hi0 = hi; lo0 = lo; dz0 = dz; d0 = ndone;
        @(negedge CLK);
        op = 2'd1; a = 32'd5; b = 32'd5; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (8) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        repeat (45) @(negedge CLK);
        chk("flush_no_done", ndone - d0, 0);
        chk("flush_hi", hi, hi0);
        chk("flush_lo", lo, lo0);
        chk("flush_dz", dz, dz0);

        // If flush and start arrive together in IDLE, flush wins.
        @(negedge CLK);
        op = 2'd1; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", busy, 0);
        repeat (40) @(negedge CLK);
        chk("flush_start_no_done", ndone - d0, 0);

        // Reset mid-operation
        d0 = ndone;
        @(negedge CLK);
        op = 2'd0; a = 32'd123; b = 32'd456; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (8) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_dz", dz, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        repeat (40) @(negedge CLK);
        chk("midrst_no_done", ndone - d0, 0);

        // The unit still works after reset.
        issue(2'd1, 32'd2, 32'd3, mk(32'd0, 32'd6, 1'b0));
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
